// File: rtl/sevseg_pkg.sv
// Shared digit codes, active-low segment patterns and reader FSM states for the
// four-digit seven-segment bus.
package sevseg_pkg;

    typedef enum logic [3:0] {
        DIG_0     = 4'd0,
        DIG_1     = 4'd1,
        DIG_2     = 4'd2,
        DIG_3     = 4'd3,
        DIG_4     = 4'd4,
        DIG_5     = 4'd5,
        DIG_6     = 4'd6,
        DIG_7     = 4'd7,
        DIG_8     = 4'd8,
        DIG_9     = 4'd9,
        DIG_MINUS = 4'd10,
        DIG_BLANK = 4'd11,
        DIG_BAD   = 4'd12
    } digit_e;

    // {CG..CA}, active-low; entry i is the glyph for decimal digit i
    localparam logic [9:0][6:0] SEG_N_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    localparam logic [6:0] SEG_N_MINUS = 7'h3F;
    localparam logic [6:0] SEG_N_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    function automatic logic is_num(input digit_e d);
        return d <= DIG_9;
    endfunction

    function automatic logic [9:0] digit_val(input digit_e d);
        return is_num(d) ? 10'(d) : 10'd0;
    endfunction

endpackage

// File: rtl/seven_segment_digit_decoder.sv
// Combinational inverse of the display driver's segment table: active-low
// {CG..CA} pattern to a digit code (0-9, MINUS, otherwise BAD).
module seven_segment_digit_decoder
    import sevseg_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output digit_e     code_o
);

    always_comb begin
        code_o = DIG_BAD;
        for (int i = 0; i < 10; i++) begin
            if (seg_n_i == SEG_N_DIGITS[i]) begin
                code_o = digit_e'(4'(i));
            end
        end
        if (seg_n_i == SEG_N_MINUS) begin
            code_o = DIG_MINUS;
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Sniffs a multiplexed four-digit seven-segment bus and recovers the signed byte.
// Define SEVSEG_READER_DP_CHECK_EN to reject frames containing a lit decimal point.
module seven_segment_reader
    import sevseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [3:0] anodes,
    input  logic [7:0] cathodes,
    output logic [7:0] value,
    output logic       valid,
    output logic       error,
    output logic       locked
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SEVSEG_READER_DP_CHECK_EN
    localparam logic DP_CHECK = 1'b1;
`else
    localparam logic DP_CHECK = 1'b0;
`endif

    logic [11:0]   sample_d, sample_q;
    logic [SW-1:0] settle_q;
    logic          taken_q;
    logic [TW-1:0] idle_q;
    state_e        state_q;
    digit_e        dig_q [4];
    logic [3:0]    dp_q, mask_q;
    logic          ferr_q;
    digit_e        pend_code_q;
    logic          pend_dp_q;
    logic [7:0]    value_q;
    logic          valid_q, error_q, locked_q;

    logic [3:0] an_act;
    logic [1:0] idx;
    logic       accept, hit, multi, timeout, dp_lit;
    digit_e     code;

    seven_segment_digit_decoder u_decoder (
        .seg_n_i (cathodes[6:0]),
        .code_o  (code)
    );

    assign sample_d = {anodes, cathodes};
    assign an_act   = ~anodes;
    assign dp_lit   = ~cathodes[7];
    assign accept   = (sample_d == sample_q) && !taken_q && (settle_q == SW'(SETTLE_CYCLES - 1));
    assign hit      = accept && (an_act != 4'b0000);
    assign multi    = $countones(an_act) > 1;
    assign timeout  = (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (an_act)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Frame legality and value, evaluated on the digits collected so far
    logic       neg, shape_ok, range_ok, dp_bad, frame_ok;
    logic [9:0] mag, mag_neg;
    logic [7:0] frame_val;

    always_comb begin
        neg      = 1'b0;
        shape_ok = 1'b0;
        case (mask_q)
            4'b0001: shape_ok = is_num(dig_q[0]);
            4'b0011: begin
                neg      = (dig_q[1] == DIG_MINUS);
                shape_ok = is_num(dig_q[0]) && (neg || (is_num(dig_q[1]) && dig_q[1] != DIG_0));
            end
            4'b0111: begin
                neg      = (dig_q[2] == DIG_MINUS);
                shape_ok = is_num(dig_q[0]) && is_num(dig_q[1])
                        && (neg ? (dig_q[1] != DIG_0) : (is_num(dig_q[2]) && dig_q[2] != DIG_0));
            end
            4'b1111: begin
                neg      = (dig_q[3] == DIG_MINUS);
                shape_ok = neg && is_num(dig_q[2]) && dig_q[2] != DIG_0
                        && is_num(dig_q[1]) && is_num(dig_q[0]);
            end
            default: shape_ok = 1'b0;
        endcase
        mag       = digit_val(dig_q[2]) * 10'd100 + digit_val(dig_q[1]) * 10'd10 + digit_val(dig_q[0]);
        mag_neg   = ~mag + 10'd1;
        range_ok  = neg ? (mag >= 10'd1 && mag <= 10'd128) : (mag <= 10'd127);
        dp_bad    = DP_CHECK && |(dp_q & mask_q);
        frame_ok  = shape_ok && range_ok && !ferr_q && !dp_bad;
        frame_val = neg ? mag_neg[7:0] : mag[7:0];
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sample_q    <= '0;
            settle_q    <= '0;
            taken_q     <= 1'b0;
            idle_q      <= '0;
            state_q     <= ST_SYNC;
            mask_q      <= '0;
            dp_q        <= '0;
            ferr_q      <= 1'b0;
            pend_code_q <= DIG_BLANK;
            pend_dp_q   <= 1'b0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= DIG_BLANK;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;

            // A sample is taken once; the counter starts at 1 on the first cycle it appears
            if (sample_d != sample_q) begin
                sample_q <= sample_d;
                settle_q <= SW'(1);
                taken_q  <= 1'b0;
            end else if (!taken_q) begin
                if (accept) taken_q <= 1'b1;
                else        settle_q <= settle_q + 1'b1;
            end

            case (state_q)
                ST_SYNC: begin
                    idle_q <= '0;
                    if (hit && an_act == 4'b0001) begin
                        for (int i = 1; i < 4; i++) dig_q[i] <= DIG_BLANK;
                        dig_q[0] <= code;
                        dp_q     <= {3'b000, dp_lit};
                        mask_q   <= 4'b0001;
                        ferr_q   <= 1'b0;
                        locked_q <= 1'b1;
                        state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (hit) begin
                        idle_q <= '0;
                        if (multi) begin
                            ferr_q <= 1'b1;
                        end else if (an_act == 4'b0001) begin
                            if (frame_ok) begin
                                value_q <= frame_val;
                                valid_q <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                            pend_code_q <= code;
                            pend_dp_q   <= dp_lit;
                            state_q     <= ST_EMIT;
                        end else begin
                            if (mask_q[idx]) ferr_q <= 1'b1;
                            dig_q[idx]  <= code;
                            dp_q[idx]   <= dp_lit;
                            mask_q[idx] <= 1'b1;
                        end
                    end else if (timeout) begin
                        mask_q   <= '0;
                        locked_q <= 1'b0;
                        state_q  <= ST_SYNC;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                ST_EMIT: begin
                    // The closing AN0 opens the next frame
                    for (int i = 1; i < 4; i++) dig_q[i] <= DIG_BLANK;
                    dig_q[0] <= pend_code_q;
                    dp_q     <= {3'b000, pend_dp_q};
                    mask_q   <= 4'b0001;
                    ferr_q   <= 1'b0;
                    state_q  <= ST_COLLECT;
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

    assign value  = value_q;
    assign valid  = valid_q;
    assign error  = error_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomised loopback bench: scans digit slots onto the bus and predicts each frame's
// outcome by matching it against the canonical rendering of every value -128..127.
module tb_seven_segment_reader;

    localparam int SETTLE = 16;
    localparam int TMO    = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] anodes = 4'hF;
    logic [7:0] cathodes = 8'hFF;
    logic [7:0] value;
    logic       valid, error, locked;

    seven_segment_reader #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .value      (value),
        .valid      (valid),
        .error      (error),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Codes: 0-9 digits, 10 minus, 11/12 illegal glyphs
    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h3F;
            11: return 7'h5A;
            default: return 7'h7F;
        endcase
    endfunction

    // How a value appears on the display: right-aligned, no leading zeros, sign in front
    function automatic void render(input int v, output logic [3:0] pres, output logic [3:0][3:0] codes);
        int mag, nd;
        mag   = (v < 0) ? -v : v;
        pres  = 4'b0001;
        codes = '0;
        codes[0] = 4'(mag % 10);
        nd = 1;
        if (mag >= 10) begin pres[1] = 1'b1; codes[1] = 4'((mag / 10) % 10); nd = 2; end
        if (mag >= 100) begin pres[2] = 1'b1; codes[2] = 4'(mag / 100); nd = 3; end
        if (v < 0) begin pres[nd] = 1'b1; codes[nd] = 4'd10; end
    endfunction

    logic [3:0]       fr_pres;
    logic [3:0][3:0]  fr_code;
    logic [3:0]       fr_dp;
    bit               fr_err;
    bit               have_frame;
    int               exp_kind[$];
    int               exp_val[$];
    int               last_val = 0;

    task automatic model_close();
        int found;
        bit bad;
        logic [3:0]      rp;
        logic [3:0][3:0] rc;
        found = 999;
        bad   = fr_err;
`ifdef SEVSEG_READER_DP_CHECK_EN
        if ((fr_dp & fr_pres) != 4'b0000) bad = 1'b1;
`endif
        for (int v = -128; v <= 127; v++) begin
            bit ok;
            render(v, rp, rc);
            ok = (rp == fr_pres);
            for (int i = 0; i < 4; i++) if (rp[i] && rc[i] != fr_code[i]) ok = 1'b0;
            if (ok) found = v;
        end
        if (!bad && found != 999) begin
            exp_kind.push_back(0);
            exp_val.push_back(found & 255);
        end else begin
            exp_kind.push_back(1);
            exp_val.push_back(0);
        end
    endtask

    // pos: -1 blank slot, 0..3 single anode, 4 two anodes at once
    task automatic send_slot(input int pos, input int code, input bit dp, input int hold);
        @(posedge clk); #1;
        if (pos < 0)       anodes = 4'hF;
        else if (pos == 4) anodes = 4'b0101;
        else               anodes = ~(4'b0001 << pos);
        cathodes = {~dp, seg_of(code)};
        if (pos == 0) begin
            if (have_frame) model_close();
            fr_pres = 4'b0001; fr_code = '0; fr_dp = '0; fr_err = 1'b0;
            fr_code[0] = 4'(code); fr_dp[0] = dp;
            have_frame = 1'b1;
        end else if (pos >= 1 && pos <= 3 && have_frame) begin
            if (fr_pres[pos]) fr_err = 1'b1;
            fr_pres[pos] = 1'b1; fr_code[pos] = 4'(code); fr_dp[pos] = dp;
        end else if (pos == 4 && have_frame) begin
            fr_err = 1'b1;
        end else if (pos < 0 && hold > TMO + SETTLE) begin
            have_frame = 1'b0;
        end
        repeat (hold - 1) @(posedge clk);
        #1;
        anodes = 4'hF;
        cathodes = 8'hFF;
        repeat ($urandom_range(1, 4)) @(posedge clk);
    endtask

    task automatic send_frame(input logic [3:0] pres, input logic [3:0][3:0] codes, input logic [3:0] dps);
        for (int p = 0; p < 4; p++) begin
            int hold;
            hold = SETTLE + 2 + int'($urandom_range(0, 20));
            if (pres[p]) send_slot(p, int'(codes[p]), dps[p], hold);
            else         send_slot(-1, 0, 1'b0, hold);
        end
    endtask

    task automatic send_value(input int v, input logic [3:0] dps);
        logic [3:0]      pr;
        logic [3:0][3:0] cd;
        render(v, pr, cd);
        send_frame(pr, cd, dps);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (valid || error) begin
                check("valid_error_exclusive", 32'(valid & error), 32'd0);
                if (exp_kind.size() != 1) begin
                    check("expected_queue", 32'(exp_kind.size()), 32'd1);
                end else begin
                    int k, ev;
                    k  = exp_kind.pop_front();
                    ev = exp_val.pop_front();
                    check("error_flag", 32'(error), 32'(k == 1));
                    if (k == 0) begin
                        check("value", 32'(value), 32'(ev));
                        $display("frame: valid value=%0h expected=%0h", value, ev);
                        last_val = ev;
                    end else begin
                        check("held_value", 32'(value), 32'(last_val));
                        $display("frame: error value=%0h held=%0h", value, last_val);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]      pr;
        logic [3:0][3:0] cd;
        have_frame = 1'b0;
        fr_pres = '0; fr_code = '0; fr_dp = '0; fr_err = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(value), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_value(5, 4'b0000);
        send_value(5, 4'b0000);
        @(negedge clk);
        check("locked_after_lock", 32'(locked), 32'd1);
        send_value(5, 4'b0000);

        send_value(-128, 4'b0000);
        send_value(-128, 4'b0000);

        // -100 switching to 99 part-way through a scan
        send_value(-100, 4'b0000);
        pr = 4'b0011; cd = '0;
        send_frame(pr, cd, 4'b0000);
        send_value(99, 4'b0000);
        send_value(99, 4'b0000);

        // {-,1,2,9} then {0,7}
        pr = 4'b1111; cd = '0; cd[3] = 4'd10; cd[2] = 4'd1; cd[1] = 4'd2; cd[0] = 4'd9;
        send_frame(pr, cd, 4'b0000);
        pr = 4'b0011; cd = '0; cd[1] = 4'd0; cd[0] = 4'd7;
        send_frame(pr, cd, 4'b0000);
        send_value(7, 4'b0000);

        // repeated AN1 and a two-anode sample
        send_slot(0, 4, 1'b0, SETTLE + 5);
        send_slot(1, 2, 1'b0, SETTLE + 5);
        send_slot(1, 2, 1'b0, SETTLE + 5);
        send_value(42, 4'b0000);
        send_slot(4, 3, 1'b0, SETTLE + 5);
        send_value(42, 4'b0000);

        // timeout drops lock; the following frames need two AN0s again
        send_slot(-1, 0, 1'b0, TMO + SETTLE + 100);
        @(negedge clk);
        check("locked_after_timeout", 32'(locked), 32'd0);
        send_value(-77, 4'b0000);
        send_value(-77, 4'b0000);
        send_value(127, 4'b0000);

        // decimal point on AN0
        send_value(3, 4'b0001);
        send_value(3, 4'b0000);
        send_value(3, 4'b0000);

        for (int n = 0; n < 40; n++) begin
            int v, r, p;
            v = int'($urandom_range(0, 255)) - 128;
            r = int'($urandom_range(0, 7));
            render(v, pr, cd);
            if (r == 0) begin
                p = int'($urandom_range(0, 3));
                cd[p] = 4'($urandom_range(0, 12));
                pr[p] = 1'b1;
            end else if (r == 1) begin
                p = int'($urandom_range(1, 3));
                pr[p] = ~pr[p];
            end
            send_frame(pr, cd, (r == 2) ? 4'($urandom_range(0, 15)) : 4'b0000);
        end
        send_value(12, 4'b0000);
        send_value(12, 4'b0000);
        @(negedge clk);
        check("locked_before_reset", 32'(locked), 32'd1);

        // asynchronous reset in the middle of a frame
        send_slot(0, 4, 1'b0, SETTLE + 6);
        #1;
        anodes = 4'b1101;
        cathodes = {1'b1, seg_of(3)};
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_value", 32'(value), 32'd0);
        check("midframe_reset_locked", 32'(locked), 32'd0);
        check("midframe_reset_queue", 32'(exp_kind.size()), 32'd0);
        have_frame = 1'b0;
        last_val = 0;
        exp_kind.delete();
        exp_val.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        anodes = 4'hF;
        cathodes = 8'hFF;
        send_value(-9, 4'b0000);
        send_value(-9, 4'b0000);
        send_value(0, 4'b0000);

        repeat (50) @(posedge clk);
        @(negedge clk);
        check("drained", 32'(exp_kind.size()), 32'd0);
        check("final_locked", 32'(locked), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
